program_counter_seq: RTL and testbench
======================================

# program_counter_seq

Parametrised program counter for the processor's instruction fetch stage, replacing the fixed 5-bit increment-only counter. Drives the instruction memory address and supports hold, increment, absolute jump, signed relative branch and an optional hardware call/return stack. All address updates are registered and wrap modulo 2^AW.

## Interface
- AW, 5: address width in bits (instruction memory depth 2^AW).
- OW, 5: branch offset width, two's complement, OW ≤ AW.
- DEPTH, 4: return stack entries, power of two ≥ 2 (used only with PC_RETURN_STACK_EN).

- clock  in  1  system clock, rising edge.
- clear_n  in  1  system clear, asynchronous, active-low.
- up  in  1  increment address by 1.
- load  in  1  absolute jump to target.
- branch  in  1  relative branch by offset.
- target  in  AW  jump/call destination.
- offset  in  OW  signed branch displacement.
- call  in  1  push return address, jump to target (stack build only).
- ret  in  1  pop return address into PC (stack build only).
- address  out  AW  current instruction address.
- stack_count  out  $clog2(DEPTH)+1  occupied stack entries (stack build only).
- stack_err  out  1  sticky overflow/underflow flag (stack build only).

## Operation
- Clear: clear_n low asynchronously forces address=0, stack_count=0, stack_err=0, and all stack entries to 0; held while low.
- Per rising edge, one operation selected by fixed priority: ret > call > load > branch > up > hold.
- hold: address unchanged.
- up: address ← address + 1.
- branch: address ← address + sign_extend(offset); offset is relative to the current (branching) address; offset 0 leaves address unchanged.
- load: address ← target.
- call: push (address + 1) mod 2^AW, address ← target, stack_count+1.
- ret: address ← top entry, stack_count−1.
- Arithmetic: all sums computed in AW bits, carry discarded; 2^AW−1 + 1 → 0, 0 + (−1) → 2^AW−1.
- call with stack_count == DEPTH: overflow; whole operation dropped (no push, no jump, address unchanged), stack_err ← 1.
- ret with stack_count == 0: underflow; dropped, address unchanged, stack_err ← 1.
- stack_err clears only on clear_n.
- Lower-priority requests asserted in the same cycle as a higher one are discarded, not queued.

## Timing
- Single-cycle: requests sampled at rising edge; new address visible immediately after that edge (one-cycle latency, no handshake).
- Inputs are level-sampled each cycle; holding up high increments every cycle.
- clear_n assertion takes effect without a clock edge; deassertion is synchronised by the system, and the first operation is taken on the first rising edge with clear_n high.
- Reset mid-operation: any in-flight call/ret is lost; stack contents invalid afterwards (count 0).
- stack_count and stack_err update on the same edge as address.

## Configuration
- PC_RETURN_STACK_EN defined: call, ret, stack_count, stack_err ports and the LIFO are present, with the behaviour above.
- Undefined: those four ports are absent, DEPTH is ignored, priority is load > branch > up > hold; no stack storage synthesised.

## Structure
- Shared package pc_pkg: operation encoding enum (PC_HOLD, PC_INC, PC_BRANCH, PC_LOAD, PC_CALL, PC_RET) and the priority-decode function mapping request bits to it.
- Sub-module pc_return_stack: DEPTH×AW LIFO with push, pop, count, full, empty; asynchronous active-low clear; instantiated only under PC_RETURN_STACK_EN.
- Top level holds the address register, the decode and the next-address adder.

## Test plan
- Clear then up held 33 cycles (AW=5) -> address 0,1,…,31,0,1; clear_n low mid-count -> address 0 immediately, without a clock edge.
- address=10, branch with offset=−3 (5'b11101) -> 7; address=30, offset=+4 -> 2 (wrap).
- load=1, branch=1, up=1 simultaneously with target=20 -> address 20.
- address=3, call target=16 -> address 16, stack_count 1; ret -> address 4, stack_count 0.
- Five nested calls, DEPTH=4 -> fifth call dropped, address unchanged, stack_err=1, stack_count 4; four rets then a fifth ret -> fifth dropped, stack_err stays 1 until clear_n.
- Build without PC_RETURN_STACK_EN -> up/load/branch tests above pass unchanged; call/ret ports absent.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types for the program counter: the operation
//                encoding and the fixed-priority request decoder.
//                Optional build macro: PC_RETURN_STACK_EN (stack build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // One operation is performed per clock edge
    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_LOAD   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_e;

    // Fixed priority: ret > call > load > branch > up > hold.
    // The non-stack build ties ret/call low, leaving load > branch > up.
    function automatic pc_op_e pc_decode(
        input logic i_ret,
        input logic i_call,
        input logic i_load,
        input logic i_branch,
        input logic i_up
    );
        pc_op_e w_op;
        if (i_ret)         w_op = PC_RET;
        else if (i_call)   w_op = PC_CALL;
        else if (i_load)   w_op = PC_LOAD;
        else if (i_branch) w_op = PC_BRANCH;
        else if (i_up)     w_op = PC_INC;
        else               w_op = PC_HOLD;
        return w_op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter_seq_if.sv
// ============================================================================
//  Module      : program_counter_seq_if
//  Description : Request/address bundle between the fetch controller
//                (master) and the program counter (slave). The call/ret
//                and stack status signals exist only when
//                PC_RETURN_STACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_counter_seq_if #(
    parameter int AW    = 5,
    parameter int OW    = 5,
    parameter int DEPTH = 4
);

    logic          up;
    logic          load;
    logic          branch;
    logic [AW-1:0] target;
    logic [OW-1:0] offset;
    logic [AW-1:0] address;

`ifdef PC_RETURN_STACK_EN
    localparam int CW = $clog2(DEPTH) + 1;

    logic          call;
    logic          ret;
    logic [CW-1:0] stack_count;
    logic          stack_err;

    modport master (
        output up, load, branch, target, offset, call, ret,
        input  address, stack_count, stack_err
    );

    modport slave (
        input  up, load, branch, target, offset, call, ret,
        output address, stack_count, stack_err
    );
`else
    modport master (
        output up, load, branch, target, offset,
        input  address
    );

    modport slave (
        input  up, load, branch, target, offset,
        output address
    );
`endif

endinterface

`default_nettype wire

// File: rtl/pc_return_stack.sv
// ============================================================================
//  Module      : pc_return_stack
//  Description : DEPTH x AW LIFO holding return addresses, with occupancy
//                count and full/empty flags. Used only when
//                PC_RETURN_STACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_return_stack #(
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  wire logic                       clock,
    input  wire logic                       clear_n,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [AW-1:0]              i_data,
    output logic      [AW-1:0]              o_data,
    output logic      [$clog2(DEPTH):0]     o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int                PW      = $clog2(DEPTH);
    localparam logic [PW:0]       c_DEPTH = (PW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW:0]   r_count;
    logic [PW:0]   w_top;

    // Count doubles as the write pointer; the top entry sits one below it
    assign w_top   = r_count - 1'b1;
    assign o_data  = r_mem[w_top[PW-1:0]];
    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);

    // LIFO storage and occupancy; push and pop are ignored when full/empty
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[r_count[PW-1:0]] <= i_data;
            r_count                <= r_count + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_counter_seq.sv
// ============================================================================
//  Module      : program_counter_seq
//  Description : Parametrised instruction-fetch program counter with hold,
//                increment, absolute jump and signed relative branch. When
//                PC_RETURN_STACK_EN is defined, a hardware call/return
//                stack is added. All sums wrap modulo 2^AW.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter_seq
    import pc_pkg::*;
#(
    parameter int AW    = 5,
    parameter int OW    = 5,
    parameter int DEPTH = 4
) (
    input  wire logic               clock,
    input  wire logic               clear_n,
    program_counter_seq_if.slave    bus
);

    pc_op_e        w_op;
    logic [AW-1:0] w_offset_ext;
    logic [AW-1:0] w_next;
    logic [AW-1:0] r_address;

    // Sign-extend the branch displacement to the address width
    assign w_offset_ext = AW'($signed(bus.offset));

`ifdef PC_RETURN_STACK_EN
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_top;
    logic [CW-1:0] w_count;
    logic          r_err;

    assign w_op   = pc_decode(bus.ret, bus.call, bus.load, bus.branch, bus.up);
    assign w_push = (w_op == PC_CALL) && !w_full;
    assign w_pop  = (w_op == PC_RET)  && !w_empty;

    pc_return_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clock   (clock),
        .clear_n (clear_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_address + 1'b1),
        .o_data  (w_top),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky error on a dropped call (full) or dropped ret (empty)
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_err <= 1'b0;
        end else if (((w_op == PC_CALL) && w_full) || ((w_op == PC_RET) && w_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.stack_count = w_count;
    assign bus.stack_err   = r_err;
`else
    assign w_op = pc_decode(1'b0, 1'b0, bus.load, bus.branch, bus.up);
`endif

    // Next-address selection; dropped stack operations fall back to hold
    always_comb begin
        w_next = r_address;
        case (w_op)
            PC_INC:    w_next = r_address + 1'b1;
            PC_BRANCH: w_next = r_address + w_offset_ext;
            PC_LOAD:   w_next = bus.target;
`ifdef PC_RETURN_STACK_EN
            PC_CALL:   w_next = w_full  ? r_address : bus.target;
            PC_RET:    w_next = w_empty ? r_address : w_top;
`endif
            default:   w_next = r_address;
        endcase
    end

    // Address register, cleared asynchronously
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_address <= '0;
        end else begin
            r_address <= w_next;
        end
    end

    assign bus.address = r_address;

endmodule

`default_nettype wire

// File: tb/tb_program_counter_seq.sv
// ============================================================================
//  Module      : tb_program_counter_seq
//  Description : Directed self-checking bench for program_counter_seq.
//                Stack tests are included when PC_RETURN_STACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_counter_seq;

    localparam int AW    = 5;
    localparam int OW    = 5;
    localparam int DEPTH = 4;

    logic clock;
    logic clear_n;
    int   n_tests;
    int   n_fail;

    program_counter_seq_if #(.AW(AW), .OW(OW), .DEPTH(DEPTH)) bus ();

    program_counter_seq #(
        .AW    (AW),
        .OW    (OW),
        .DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Set all requests; call/ret only exist in the stack build
    task automatic drive(input logic up, input logic load, input logic branch,
                         input logic [AW-1:0] target, input logic [OW-1:0] offset,
                         input logic call, input logic ret);
        bus.up     = up;
        bus.load   = load;
        bus.branch = branch;
        bus.target = target;
        bus.offset = offset;
`ifdef PC_RETURN_STACK_EN
        bus.call   = call;
        bus.ret    = ret;
`else
        if (call || ret) $display("[TB] note: call/ret ignored in this build");
`endif
    endtask

    // Advance one edge and sample just after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_n = 1'b0;
        drive(0, 0, 0, '0, '0, 0, 0);

        #12;
        check("reset_address", 32'(bus.address), 0);
`ifdef PC_RETURN_STACK_EN
        check("reset_count", 32'(bus.stack_count), 0);
        check("reset_err", 32'(bus.stack_err), 0);
`endif

        // Increment held for 33 edges: 1..31, 0, 1
        clear_n = 1'b1;
        drive(1, 0, 0, '0, '0, 0, 0);
        for (int i = 1; i <= 33; i++) begin
            step();
            check($sformatf("up_%0d", i), 32'(bus.address), 32'(i % 32));
        end
        step();
        step();
        check("up_pre_clear", 32'(bus.address), 3);

        // Asynchronous clear mid-count, no clock edge
        clear_n = 1'b0;
        #1;
        check("async_clear", 32'(bus.address), 0);
        step();
        check("clear_held", 32'(bus.address), 0);
        clear_n = 1'b1;
        drive(0, 0, 0, '0, '0, 0, 0);

        // Branch backwards: 10 - 3 = 7
        drive(0, 1, 0, 5'd10, '0, 0, 0); step();
        check("load_10", 32'(bus.address), 10);
        drive(0, 0, 1, '0, 5'b11101, 0, 0); step();
        check("branch_m3", 32'(bus.address), 7);

        // Branch forward with wrap: 30 + 4 = 2
        drive(0, 1, 0, 5'd30, '0, 0, 0); step();
        check("load_30", 32'(bus.address), 30);
        drive(0, 0, 1, '0, 5'd4, 0, 0); step();
        check("branch_p4_wrap", 32'(bus.address), 2);

        // Offset zero and plain hold leave the address alone
        drive(0, 0, 1, '0, 5'd0, 0, 0); step();
        check("branch_zero", 32'(bus.address), 2);
        drive(0, 0, 0, '0, '0, 0, 0); step();
        check("hold", 32'(bus.address), 2);

        // Priority: load beats branch and up; branch beats up
        drive(1, 1, 1, 5'd20, 5'd3, 0, 0); step();
        check("prio_load", 32'(bus.address), 20);
        drive(1, 0, 1, 5'd9, 5'd5, 0, 0); step();
        check("prio_branch", 32'(bus.address), 25);

        // 0 + (-1) wraps to 31
        drive(0, 1, 0, 5'd0, '0, 0, 0); step();
        check("load_0", 32'(bus.address), 0);
        drive(0, 0, 1, '0, 5'b11111, 0, 0); step();
        check("branch_m1_wrap", 32'(bus.address), 31);

`ifdef PC_RETURN_STACK_EN
        // Single call/return pair
        drive(0, 1, 0, 5'd3, '0, 0, 0); step();
        drive(0, 0, 0, 5'd16, '0, 1, 0); step();
        check("call_addr", 32'(bus.address), 16);
        check("call_count", 32'(bus.stack_count), 1);
        drive(0, 0, 0, '0, '0, 0, 1); step();
        check("ret_addr", 32'(bus.address), 4);
        check("ret_count", 32'(bus.stack_count), 0);

        // Four nested calls fill the stack (returns 5, 9, 13, 17)
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 5'(4 * i + 4), '0, 1, 0); step();
            check($sformatf("ncall_%0d", i), 32'(bus.address), 32'(4 * i + 4));
        end
        check("full_count", 32'(bus.stack_count), 4);
        check("full_err", 32'(bus.stack_err), 0);
        drive(0, 0, 0, 5'd24, '0, 1, 0); step();
        check("ovf_addr", 32'(bus.address), 20);
        check("ovf_count", 32'(bus.stack_count), 4);
        check("ovf_err", 32'(bus.stack_err), 1);

        // Unwind: 17, 13, 9, 5
        for (int i = 4; i >= 1; i--) begin
            drive(0, 0, 0, '0, '0, 0, 1); step();
            check($sformatf("nret_%0d", i), 32'(bus.address), 32'(4 * i + 1));
        end
        drive(0, 0, 0, '0, '0, 0, 1); step();
        check("udf_addr", 32'(bus.address), 5);
        check("udf_count", 32'(bus.stack_count), 0);
        check("udf_err", 32'(bus.stack_err), 1);

        // Error is sticky until clear
        drive(1, 0, 0, '0, '0, 0, 0); step();
        check("err_sticky_addr", 32'(bus.address), 6);
        check("err_sticky", 32'(bus.stack_err), 1);
        clear_n = 1'b0;
        #1;
        check("err_cleared", 32'(bus.stack_err), 0);
        check("count_cleared", 32'(bus.stack_count), 0);
        clear_n = 1'b1;
`endif

        drive(0, 0, 0, '0, '0, 0, 0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
